count_acc: RTL and testbench

- Sequential population counter for the syn_lib arithmetic library. Accumulates the number of ones (or zeros) over a frame of M words of N bits each, streamed one word per accepted cycle.
- Each word's popcount is combinational; the accumulator, word counter and FSM are registered.
- Intended for garbled sequential circuits where the combined vector N*M is too wide to count in one cycle.
- Adds a threshold compare output and a start/done handshake.

---
 rtl/count_acc.sv | 135 +++++++++++++
 tb/tb_count_acc.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_acc.sv
// count_acc: sequential population counter over a frame of M words of N bits.
// One word is accepted per cycle while in ACC with in_valid high. Its popcount
// (ones for MODE=0, zeros for MODE=1) is added to a K-bit accumulator. When the
// M-th word is accepted, the frame total is published on S together with a
// threshold compare (ge), and done pulses for one cycle.
module count_acc #(
  parameter int N    = 8,
  parameter int M    = 4,
  parameter int MODE = 0,
  localparam int K   = $clog2(N * M + 1),
  localparam int CW  = $clog2(M + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  input  logic [N-1:0] A,
  input  logic [K-1:0] thr,
  output logic [K-1:0] S,
  output logic         ge,
  output logic         done,
  output logic         busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of set bits in a word, sized to the accumulator width.
  function automatic logic [K-1:0] popcount(input logic [N-1:0] v);
    logic [K-1:0] c;
    c = {K{1'b0}};
    for (int i = 0; i < N; i++) begin
      c = c + K'(v[i]);
    end
    return c;
  endfunction

  state_t        r_state;
  state_t        w_next_state;
  logic [K-1:0]  r_acc;
  logic [CW-1:0] r_wcnt;
  logic [K-1:0]  r_thr;
  logic [K-1:0]  r_s;
  logic          r_ge;
  logic          r_done;
  logic          r_busy;

  logic [N-1:0]  w_word;
  logic [K-1:0]  w_cnt;
  logic [K-1:0]  w_sum;
  logic          w_last;
  logic          w_arm;
  logic          w_accept;

  // Per-word count and the running sum it would produce.
  always_comb begin
    w_word = A;
    if (MODE != 0) begin
      w_word = ~A;
    end else begin
      w_word = A;
    end
    w_cnt    = popcount(w_word);
    w_sum    = r_acc + w_cnt;
    w_last   = (r_wcnt == CW'(M - 1));
    w_arm    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    w_accept = in_valid && (r_state == ST_ACC);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; start is only honoured outside ACC.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = ST_ACC;
        else       w_next_state = ST_IDLE;
      end
      ST_ACC: begin
        if (in_valid && w_last) w_next_state = ST_DONE;
        else                    w_next_state = ST_ACC;
      end
      ST_DONE: begin
        if (start) w_next_state = ST_ACC;
        else       w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Datapath: arm on start, accumulate accepted words, publish frame result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= {K{1'b0}};
      r_wcnt <= {CW{1'b0}};
      r_thr  <= {K{1'b0}};
      r_s    <= {K{1'b0}};
      r_ge   <= 1'b0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_done <= (w_next_state == ST_DONE);
      r_busy <= (w_next_state == ST_ACC);
      if (w_arm) begin
        r_acc  <= {K{1'b0}};
        r_wcnt <= {CW{1'b0}};
        r_thr  <= thr;
      end else if (w_accept) begin
        r_acc  <= w_sum;
        r_wcnt <= r_wcnt + CW'(1);
      end
      if (w_accept && w_last) begin
        r_s  <= w_sum;
        r_ge <= (w_sum >= r_thr);
      end
    end
  end

  assign S    = r_s;
  assign ge   = r_ge;
  assign done = r_done;
  assign busy = r_busy;

endmodule

// File: tb/tb_count_acc.sv
// Directed bench for count_acc: three instances cover (N=8,M=4,MODE=0),
// (N=8,M=4,MODE=1) and (N=1,M=1,MODE=0). Expected values are hand computed.
module tb_count_acc;

  logic clk;
  logic rst;

  // Instance 0: N=8, M=4, MODE=0, K=6
  logic       s0_start, s0_iv;
  logic [7:0] s0_a;
  logic [5:0] s0_thr, s0_s;
  logic       s0_ge, s0_done, s0_busy;

  // Instance 1: N=8, M=4, MODE=1, K=6
  logic       s1_start, s1_iv;
  logic [7:0] s1_a;
  logic [5:0] s1_thr, s1_s;
  logic       s1_ge, s1_done, s1_busy;

  // Instance 2: N=1, M=1, MODE=0, K=1
  logic       s2_start, s2_iv;
  logic [0:0] s2_a;
  logic [0:0] s2_thr, s2_s;
  logic       s2_ge, s2_done, s2_busy;

  int tests_run;
  int tests_failed;

  count_acc #(.N(8), .M(4), .MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(s0_start), .in_valid(s0_iv), .A(s0_a),
    .thr(s0_thr), .S(s0_s), .ge(s0_ge), .done(s0_done), .busy(s0_busy));

  count_acc #(.N(8), .M(4), .MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(s1_start), .in_valid(s1_iv), .A(s1_a),
    .thr(s1_thr), .S(s1_s), .ge(s1_ge), .done(s1_done), .busy(s1_busy));

  count_acc #(.N(1), .M(1), .MODE(0)) u_dut2 (
    .clk(clk), .rst(rst), .start(s2_start), .in_valid(s2_iv), .A(s2_a),
    .thr(s2_thr), .S(s2_s), .ge(s2_ge), .done(s2_done), .busy(s2_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if ({s0_s, s0_ge, s0_done, s0_busy} !== 9'd0) begin
      tests_failed++;
      $display("FAIL reset0: got S=%0d ge=%0b done=%0b busy=%0b, want all 0", s0_s, s0_ge, s0_done, s0_busy);
    end
    tests_run++;
    if ({s1_s, s1_ge, s1_done, s1_busy, s2_s, s2_ge, s2_done, s2_busy} !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset12: got S1=%0d S2=%0d busy1=%0b busy2=%0b, want 0", s1_s, s2_s, s1_busy, s2_busy);
    end
  endtask

  task automatic test_full_ones();
    s0_start = 1'b1; s0_thr = 6'd32;
    tick();
    s0_start = 1'b0;
    tests_run++;
    if (s0_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL ones_busy: got %0b want 1", s0_busy);
    end
    s0_iv = 1'b1; s0_a = 8'hFF;
    for (int i = 0; i < 4; i++) tick();
    s0_iv = 1'b0;
    tests_run++;
    if ({s0_s, s0_ge, s0_done, s0_busy} !== {6'd32, 1'b1, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL ones_result: got S=%0d ge=%0b done=%0b busy=%0b, want 32 1 1 0", s0_s, s0_ge, s0_done, s0_busy);
    end
    tick();
    tests_run++;
    if ({s0_s, s0_done} !== {6'd32, 1'b0}) begin
      tests_failed++;
      $display("FAIL ones_hold: got S=%0d done=%0b, want 32 0", s0_s, s0_done);
    end
  endtask

  task automatic test_gaps();
    s0_start = 1'b1; s0_thr = 6'd11;
    tick();
    s0_start = 1'b0;
    s0_iv = 1'b1; s0_a = 8'h01;
    tick();
    s0_iv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if ({s0_busy, s0_done} !== 2'b10) begin
        tests_failed++;
        $display("FAIL gap_busy[%0d]: got busy=%0b done=%0b, want 1 0", i, s0_busy, s0_done);
      end
    end
    s0_iv = 1'b1; s0_a = 8'h03;
    tick();
    s0_a = 8'h07;
    tick();
    tests_run++;
    if (s0_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL gap_early_done: got %0b want 0", s0_done);
    end
    s0_a = 8'h0F;
    tick();
    s0_iv = 1'b0;
    tests_run++;
    if ({s0_s, s0_ge, s0_done} !== {6'd10, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL gap_result: got S=%0d ge=%0b done=%0b, want 10 0 1", s0_s, s0_ge, s0_done);
    end
    tick();
  endtask

  task automatic test_zeros_mode();
    s1_start = 1'b1; s1_thr = 6'd16;
    tick();
    s1_start = 1'b0;
    s1_iv = 1'b1;
    s1_a = 8'h00; tick();
    s1_a = 8'hFF; tick();
    s1_a = 8'h0F; tick();
    s1_a = 8'hF0; tick();
    s1_iv = 1'b0;
    tests_run++;
    if ({s1_s, s1_ge, s1_done} !== {6'd16, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL zeros_result: got S=%0d ge=%0b done=%0b, want 16 1 1", s1_s, s1_ge, s1_done);
    end
    tick();
  endtask

  task automatic test_midframe_reset();
    s0_start = 1'b1; s0_thr = 6'd5;
    tick();
    s0_start = 1'b0;
    s0_iv = 1'b1; s0_a = 8'hFF;
    tick(); tick();
    s0_iv = 1'b0; s0_start = 1'b1;
    tick();
    s0_start = 1'b0;
    tests_run++;
    if (s0_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_start_ignored: got busy=%0b want 1", s0_busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if ({s0_s, s0_ge, s0_done, s0_busy} !== 9'd0) begin
      tests_failed++;
      $display("FAIL mid_reset: got S=%0d ge=%0b done=%0b busy=%0b, want all 0", s0_s, s0_ge, s0_done, s0_busy);
    end
    // IDLE ignores data words.
    s0_iv = 1'b1; s0_a = 8'hFF;
    tick();
    s0_iv = 1'b0;
    tests_run++;
    if ({s0_busy, s0_done} !== 2'b00) begin
      tests_failed++;
      $display("FAIL idle_ignore: got busy=%0b done=%0b, want 0 0", s0_busy, s0_done);
    end
    s0_start = 1'b1;
    tick();
    s0_start = 1'b0;
    s0_iv = 1'b1; s0_a = 8'hAA;
    for (int i = 0; i < 4; i++) tick();
    s0_iv = 1'b0;
    tests_run++;
    if ({s0_s, s0_ge, s0_done} !== {6'd16, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL after_reset_frame: got S=%0d ge=%0b done=%0b, want 16 1 1", s0_s, s0_ge, s0_done);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    s0_start = 1'b1; s0_thr = 6'd0;
    tick();
    s0_start = 1'b0;
    s0_iv = 1'b1; s0_a = 8'hFF;
    for (int i = 0; i < 4; i++) tick();
    tests_run++;
    if ({s0_s, s0_done} !== {6'd32, 1'b1}) begin
      tests_failed++;
      $display("FAIL b2b_frame1: got S=%0d done=%0b, want 32 1", s0_s, s0_done);
    end
    // In the DONE cycle: start together with a valid word that must not count.
    s0_start = 1'b1; s0_iv = 1'b1; s0_a = 8'hFF;
    tick();
    s0_start = 1'b0;
    tests_run++;
    if ({s0_s, s0_done, s0_busy} !== {6'd32, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL b2b_rearm: got S=%0d done=%0b busy=%0b, want 32 0 1", s0_s, s0_done, s0_busy);
    end
    s0_a = 8'h01;
    for (int i = 0; i < 3; i++) tick();
    tests_run++;
    if ({s0_s, s0_done} !== {6'd32, 1'b0}) begin
      tests_failed++;
      $display("FAIL b2b_hold: got S=%0d done=%0b, want 32 0", s0_s, s0_done);
    end
    tick();
    s0_iv = 1'b0;
    tests_run++;
    if ({s0_s, s0_ge, s0_done} !== {6'd4, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL b2b_frame2: got S=%0d ge=%0b done=%0b, want 4 1 1", s0_s, s0_ge, s0_done);
    end
    tick();
  endtask

  task automatic test_single_bit();
    s2_start = 1'b1; s2_thr = 1'b1;
    tick();
    s2_start = 1'b0;
    s2_iv = 1'b1; s2_a = 1'b1;
    tick();
    s2_iv = 1'b0;
    tests_run++;
    if ({s2_s, s2_ge, s2_done, s2_busy} !== 4'b1110) begin
      tests_failed++;
      $display("FAIL n1_one: got S=%0d ge=%0b done=%0b busy=%0b, want 1 1 1 0", s2_s, s2_ge, s2_done, s2_busy);
    end
    tick();
    s2_start = 1'b1; s2_thr = 1'b1;
    tick();
    s2_start = 1'b0;
    s2_iv = 1'b1; s2_a = 1'b0;
    tick();
    s2_iv = 1'b0;
    tests_run++;
    if ({s2_s, s2_ge, s2_done} !== 3'b001) begin
      tests_failed++;
      $display("FAIL n1_zero: got S=%0d ge=%0b done=%0b, want 0 0 1", s2_s, s2_ge, s2_done);
    end
    tick();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b0;
    s0_start = 1'b0; s0_iv = 1'b0; s0_a = 8'h00; s0_thr = 6'd0;
    s1_start = 1'b0; s1_iv = 1'b0; s1_a = 8'h00; s1_thr = 6'd0;
    s2_start = 1'b0; s2_iv = 1'b0; s2_a = 1'b0;  s2_thr = 1'b0;
    #2;
    test_reset();
    test_full_ones();
    test_gaps();
    test_zeros_mode();
    test_midframe_reset();
    test_back_to_back();
    test_single_bit();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
